// File: rtl/mem_bus_pkg.sv
// Shared types and address helpers for the CPU data-memory bus.
//   WORD_BYTES   bytes per bus word
//   rd_entry_t   one read-pipeline slot: valid flag plus load data
//   addr_in_range / addr_ok   decode of a byte address against a word array
package mem_bus_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } rd_entry_t;

    // True when addr lies in base .. base+depth*WORD_BYTES-1. The offset is
    // compared with one extra bit so the span never overflows, and the
    // explicit lower-bound test rejects subtract wrap below base.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base,
                                           input int unsigned       depth);
        logic [ADDR_W:0]   span;
        logic [ADDR_W-1:0] off;
        span = (ADDR_W+1)'(depth) * (ADDR_W+1)'(WORD_BYTES);
        off  = addr - base;
        return (addr >= base) && ((ADDR_W+1)'(off) < span);
    endfunction

    // Word-aligned and inside the array.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       depth);
        return (addr[1:0] == 2'b00) && addr_in_range(addr, base, depth);
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Fixed-latency read return pipeline.
//   clk, rst_n   clock and asynchronous active-low clear of every stage
//   in_entry     slot entering stage 0 on each rising edge
//   out_entry    slot in the last stage (STAGES-1 edges after entry)
module dmem_rd_pipe
    import mem_bus_pkg::*;
#(
    parameter int unsigned STAGES = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  rd_entry_t in_entry,
    output rd_entry_t out_entry
);

    rd_entry_t stage [STAGES];

    // Shift one stage per edge; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_entry;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_entry = stage[STAGES-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target on the CPU dmem bus.
//   clk, rst_n     clock; asynchronous active-low reset
//   dmem_wen       1 = store this cycle, 0 = load this cycle
//   dmem_addr      byte address
//   dmem_data      store data in; load data out while dmem_rvalid=1
//   dmem_rvalid    load result present on dmem_data this cycle
//   err_misalign   pulse: previous access had dmem_addr[1:0] != 0
//   err_range      pulse: previous access was outside the array window
module dmem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    inout  wire  [31:0] dmem_data,
    output logic        dmem_rvalid,
    output logic        err_misalign,
    output logic        err_range
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // Array contents survive reset; they start at zero.
    logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             aligned;
    logic             in_range;
    logic             access_ok;
    rd_entry_t        issue_entry;
    rd_entry_t        out_entry;

    // Address decode shared by stores, loads and the error flags.
    always_comb begin
        offset    = dmem_addr - BASE_ADDR;
        idx       = IDX_W'(offset >> 2);
        aligned   = (dmem_addr[1:0] == 2'b00);
        in_range  = addr_in_range(dmem_addr, BASE_ADDR, DEPTH_WORDS);
        access_ok = addr_ok(dmem_addr, BASE_ADDR, DEPTH_WORDS);
    end

    // Every edge issues a slot; only loads mark it valid. Bad loads return zero.
    always_comb begin
        issue_entry       = '0;
        issue_entry.valid = !dmem_wen;
        if (!dmem_wen && access_ok) begin
            issue_entry.data = mem[idx];
        end
    end

    // Store port; rejected accesses leave the array untouched.
    always_ff @(posedge clk) begin
        if (dmem_wen && access_ok) begin
            mem[idx] <= dmem_data;
        end
    end

    // Error flags describe the access issued at the most recent edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            err_misalign <= !aligned;
            err_range    <= !in_range;
        end
    end

    dmem_rd_pipe #(
        .STAGES (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_entry  (issue_entry),
        .out_entry (out_entry)
    );

    // A store cycle pre-empts a returning result: it is dropped, not retried.
    assign dmem_rvalid = out_entry.valid && !dmem_wen;
    assign dmem_data   = dmem_rvalid ? out_entry.data : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int unsigned D0 = 16;
    localparam int unsigned L0 = 3;
    localparam logic [31:0] B0 = 32'h0000_0100;
    localparam int unsigned D1 = 1024;
    localparam int unsigned L1 = 1;
    localparam logic [31:0] B1 = 32'h0000_0000;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wen     = 1'b0;
    logic [31:0] addr    = 32'h0;
    logic [31:0] drv_val = 32'h0;
    logic        drv_en  = 1'b0;

    wire  [31:0] bus0;
    wire  [31:0] bus1;
    logic        rv0, rv1, em0, em1, er0, er1;

    assign bus0 = drv_en ? drv_val : 32'hzzzz_zzzz;
    assign bus1 = drv_en ? drv_val : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(D0), .READ_LAT(L0), .BASE_ADDR(B0)) u0 (
        .clk(clk), .rst_n(rst_n), .dmem_wen(wen), .dmem_addr(addr),
        .dmem_data(bus0), .dmem_rvalid(rv0), .err_misalign(em0), .err_range(er0));

    dmem_responder #(.DEPTH_WORDS(D1), .READ_LAT(L1), .BASE_ADDR(B1)) u1 (
        .clk(clk), .rst_n(rst_n), .dmem_wen(wen), .dmem_addr(addr),
        .dmem_data(bus1), .dmem_rvalid(rv1), .err_misalign(em1), .err_range(er1));

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] mm [2][1024];
    logic [31:0] sched [longint];
    logic        exp_m [2];
    logic        exp_r [2];
    longint      edge_n = 0;

    function automatic longint skey(input int i, input longint e);
        return longint'(i) * 64'sd1000000 + e;
    endfunction

    function automatic longint unsigned base_of(input int i);
        return (i == 0) ? longint'(B0) : longint'(B1);
    endfunction

    function automatic longint unsigned bytes_of(input int i);
        return (i == 0) ? longint'(D0) * 4 : longint'(D1) * 4;
    endfunction

    function automatic bit in_win(input int i, input logic [31:0] a);
        longint unsigned av;
        av = longint'(a);
        return (av >= base_of(i)) && (av < base_of(i) + bytes_of(i));
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_m[i] = 1'b0;
            exp_r[i] = 1'b0;
            for (int j = 0; j < 1024; j++) mm[i][j] = 32'h0;
        end
    end

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            bit     rng;
            bit     ok;
            int     idx;
            int     lat;
            lat = (i == 0) ? int'(L0) : int'(L1);
            if (rst_n) begin
                rng      = in_win(i, addr);
                ok       = rng && (addr % 4 == 0);
                exp_m[i] = (addr % 4 != 0);
                exp_r[i] = !rng;
                idx      = ok ? int'((longint'(addr) - base_of(i)) / 4) : 0;
                if (wen) begin
                    if (ok) mm[i][idx] = drv_val;
                end else begin
                    sched[skey(i, edge_n + lat - 1)] = ok ? mm[i][idx] : 32'h0;
                end
            end else begin
                exp_m[i] = 1'b0;
                exp_r[i] = 1'b0;
            end
        end
    end

    always @(negedge rst_n) begin
        sched.delete();
        for (int i = 0; i < 2; i++) begin
            exp_m[i] = 1'b0;
            exp_r[i] = 1'b0;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        ev;
            logic [31:0] ed;
            longint      k;
            k  = skey(i, edge_n);
            ev = 1'b0;
            ed = 32'h0;
            if (sched.exists(k)) begin
                ev = rst_n && !wen;
                ed = sched[k];
                sched.delete(k);
            end
            chk(i == 0 ? "u0_rvalid" : "u1_rvalid", i == 0 ? 32'(rv0) : 32'(rv1), 32'(ev));
            if (ev) chk(i == 0 ? "u0_data" : "u1_data", i == 0 ? bus0 : bus1, ed);
            chk(i == 0 ? "u0_err_misalign" : "u1_err_misalign",
                i == 0 ? 32'(em0) : 32'(em1), 32'(exp_m[i]));
            chk(i == 0 ? "u0_err_range" : "u1_err_range",
                i == 0 ? 32'(er0) : 32'(er1), 32'(exp_r[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic setin(input logic w, input logic [31:0] a, input logic [31:0] d);
        wen     = w;
        addr    = a;
        drv_val = d;
        drv_en  = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

    initial begin
        logic [31:0] bnd [8];
        bnd[0] = B0 - 32'd4;   bnd[1] = B0 + 32'd64;  bnd[2] = B0 + 32'd60;
        bnd[3] = 32'h0000_1000; bnd[4] = 32'h0000_0FFC; bnd[5] = 32'hFFFF_FFFC;
        bnd[6] = 32'h0;        bnd[7] = B0;

        setin(1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("reset_rvalid0", 32'(rv0), 32'h0);
        chk("reset_rvalid1", 32'(rv1), 32'h0);
        chk("reset_errs", {28'h0, em0, er0, em1, er1}, 32'h0);
        @(posedge clk); #1;

        // Store then load, one-cycle latency on u1.
        setin(1'b1, 32'h10, 32'hDEAD_BEEF); tick();
        setin(1'b0, 32'h10, 32'h0);         tick();
        setin(1'b0, 32'h104, 32'h0); #1;
        chk("lat1_rvalid", 32'(rv1), 32'h1);
        chk("lat1_data", bus1, 32'hDEAD_BEEF);
        chk("u0_below_base_range", 32'(er0), 32'h1);

        // Back-to-back loads with three-cycle latency on u0.
        setin(1'b1, 32'h100, 32'h1); tick();
        setin(1'b1, 32'h104, 32'h2); tick();
        setin(1'b1, 32'h108, 32'h3); tick();
        setin(1'b0, 32'h100, 32'h0); tick();
        setin(1'b0, 32'h104, 32'h0); tick();
        setin(1'b0, 32'h108, 32'h0); tick();
        setin(1'b0, 32'h10C, 32'h0); #1;
        chk("lat3_first_rvalid", 32'(rv0), 32'h1);
        chk("lat3_first", bus0, 32'h1);
        tick(); chk("lat3_second", bus0, 32'h2);
        tick(); chk("lat3_third", bus0, 32'h3);

        // Asynchronous reset while loads are in flight.
        setin(1'b0, 32'h100, 32'h0); tick();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid0", 32'(rv0), 32'h0);
        chk("async_rst_rvalid1", 32'(rv1), 32'h0);
        chk("async_rst_errs", {28'h0, em0, er0, em1, er1}, 32'h0);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        tick(); chk("no_stale_1", 32'(rv0), 32'h0);
        tick(); chk("no_stale_2", 32'(rv0), 32'h0);
        tick(); chk("post_rst_load", bus0, 32'h1);

        // Misaligned store must not modify the containing word.
        setin(1'b1, 32'h4, 32'h0000_CAFE); tick();
        setin(1'b1, 32'h6, 32'h5);         tick();
        setin(1'b0, 32'h4, 32'h0); #1;
        chk("misalign_store_flag", 32'(em1), 32'h1);
        chk("misalign_store_norange", 32'(er1), 32'h0);
        tick(); chk("misalign_pulse_end", 32'(em1), 32'h0);
        chk("misalign_unchanged", bus1, 32'h0000_CAFE);
        setin(1'b0, 32'h6, 32'h0); tick();
        chk("misalign_load_flag", 32'(em1), 32'h1);
        chk("misalign_load_rvalid", 32'(rv1), 32'h1);
        chk("misalign_load_zero", bus1, 32'h0);

        // Range edges on the 16-word u0 window (0x100..0x13F).
        setin(1'b1, 32'h13C, 32'h77);  tick();
        setin(1'b0, 32'h140, 32'h0);   tick();
        chk("range_top_flag", 32'(er0), 32'h1);
        setin(1'b0, 32'h13C, 32'h0);   tick();
        chk("range_last_ok", 32'(er0), 32'h0);
        tick(); chk("range_top_zero_v", 32'(rv0), 32'h1);
        chk("range_top_zero", bus0, 32'h0);
        tick(); chk("range_last_data", bus0, 32'h77);
        setin(1'b0, 32'h1000, 32'h0);  tick();
        chk("u1_range_top", 32'(er1), 32'h1);
        chk("u1_range_zero", bus1, 32'h0);
        setin(1'b0, 32'hFFFF_FFFC, 32'h0); tick();
        chk("wrap_range", {30'h0, er0, er1}, 32'h3);

        // Store in the return cycle drops the result and still writes.
        setin(1'b0, 32'h20, 32'h0);        tick();
        setin(1'b1, 32'h20, 32'h1234_5678); #1;
        chk("drop_rvalid", 32'(rv1), 32'h0);
        chk("drop_bus_tb_value", bus1, 32'h1234_5678);
        tick();
        setin(1'b0, 32'h20, 32'h0);        tick();
        chk("drop_store_written", bus1, 32'h1234_5678);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            logic        w;
            logic [31:0] a;
            w = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: a = B0 + 32'($urandom_range(0, 15)) * 4;
                1: a = 32'($urandom_range(0, 1023)) * 4;
                2: a = B0 + 32'($urandom_range(0, 63));
                3: a = bnd[$urandom_range(0, 7)];
                4: a = $urandom;
                default: a = B0 + 32'($urandom_range(0, 3)) * 4;
            endcase
            setin(w, a, $urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst_n  = 1'b0;
                wen    = 1'b0;
                drv_en = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #2 rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        setin(1'b0, B0, 32'h0);
        repeat (6) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
